// File: rtl/rsa_pkg.sv
// Purpose : shared types and defaults for the RSA stream packer/unpacker pair.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package rsa_pkg;

    localparam int DEFAULT_WIDTH = 512;  // key-exponent width
    localparam int DEFAULT_IN_W  = 32;   // stream word width

    // Packer state: collecting words, or presenting a finished block to the core.
    typedef enum logic {
        PK_FILL = 1'b0,
        PK_HOLD = 1'b1
    } pk_state_t;

    // Operand block width used by the RSA core for a given key width.
    function automatic int blk_width(input int width);
        return width * 4;
    endfunction

endpackage

// File: rtl/rsa_word_packer.sv
// Purpose : packs a narrow valid/ready word stream into one WIDTH*4-bit operand block for the RSA core.
// Latency : last accepted word -> blk_valid 1 cycle; core_done -> s_ready 1 cycle (1-cycle gap between blocks).
// Backpr. : s_ready is low for the whole time a block is held; pending upstream word waits until release.
//
// Ports:
//   aclk, aresetn      clock (rising edge) and asynchronous active-low reset
//   s_data/s_valid/s_last/s_ready   input word stream; s_last closes a short, zero-padded block
//   blk_data/blk_valid/blk_words    packed block (word k at [k*IN_W +: IN_W]), level-held until core_done
//   core_done          one-cycle pulse from the core releasing the held block
//   err_done           sticky flag: core_done arrived while no block was held
module rsa_word_packer
    import rsa_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    parameter  int IN_W   = DEFAULT_IN_W,
    localparam int BLK_W  = blk_width(WIDTH),
    localparam int NWORDS = BLK_W / IN_W,
    localparam int CW     = $clog2(NWORDS + 1)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [BLK_W-1:0] blk_data,
    output logic             blk_valid,
    output logic [CW-1:0]    blk_words,
    input  logic             core_done,
    output logic             err_done
);

    generate
        if ((IN_W <= 0) || (BLK_W % IN_W != 0)) begin : g_bad_in_w
            $error("rsa_word_packer: block width must be a whole number of IN_W words");
        end
    endgenerate

    pk_state_t                    state;
    logic [CW-1:0]                cnt;
    logic [NWORDS-1:0][IN_W-1:0]  slot_q;

    logic accept;
    logic closing;

    // s_ready is a register, so accept depends on s_valid only through the data
    // path; nothing combinational feeds back into s_ready itself.
    assign accept  = s_valid && s_ready;
    assign closing = accept && (s_last || (cnt == CW'(NWORDS - 1)));

    assign blk_data = slot_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= PK_FILL;
            cnt       <= '0;
            slot_q    <= '0;
            blk_valid <= 1'b0;
            blk_words <= '0;
            err_done  <= 1'b0;
            s_ready   <= 1'b0;
        end else begin
            case (state)
                PK_FILL: begin
                    // A done pulse with nothing held is a protocol error from the core;
                    // it must not disturb the block being collected.
                    if (core_done) begin
                        err_done <= 1'b1;
                    end

                    if (accept) begin
                        for (int k = 0; k < NWORDS; k++) begin
                            if (cnt == CW'(k)) begin
                                slot_q[k] <= s_data;
                            end
                        end
                        cnt <= cnt + CW'(1);
                    end

                    // The word accepted on this edge is already stored above, so the
                    // block is complete the moment we enter HOLD.
                    if (closing) begin
                        state     <= PK_HOLD;
                        blk_valid <= 1'b1;
                        blk_words <= cnt + CW'(1);
                        s_ready   <= 1'b0;
                    end else begin
                        s_ready   <= 1'b1;
                    end
                end

                PK_HOLD: begin
                    // Release only; s_ready was low this cycle so no word is taken.
                    // Clearing the buffer here is what zero-pads the next short block.
                    if (core_done) begin
                        state     <= PK_FILL;
                        blk_valid <= 1'b0;
                        cnt       <= '0;
                        slot_q    <= '0;
                        s_ready   <= 1'b1;
                    end
                end

                default: begin
                    state <= PK_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_word_packer.sv
// Purpose : self-checking bench for rsa_word_packer (table vectors, hand corner cases, random blocks).
// Latency : n/a.
// Backpr. : n/a.
module tb_rsa_word_packer;

    localparam int BLK_W = 2048;
    localparam int NW    = 64;

    logic              aclk;
    logic              aresetn;
    logic [31:0]       s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [BLK_W-1:0]  blk_data;
    logic              blk_valid;
    logic [6:0]        blk_words;
    logic              core_done;
    logic              err_done;

    int total = 0;
    int bad   = 0;
    int nblk  = 0;

    logic [31:0] mdl_q[$];   // words the model believes are in the current block

    rsa_word_packer dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_words (blk_words),
        .core_done (core_done),
        .err_done  (err_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int          nw;
        bit          last;
        logic [31:0] base;
        int          exp_words;
        logic [63:0] exp_lo;   // expected blk_data[63:0]
        logic [31:0] exp_hi;   // expected blk_data[2047:2016]
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        total++;
        if (act !== exp) begin
            int idx;
            idx = 0;
            bad++;
            for (int i = NW - 1; i >= 0; i--)
                if (act[i*32 +: 32] !== exp[i*32 +: 32]) idx = i;
            $display("FAIL %s word %0d actual=%h required=%h", nm, idx, act[idx*32 +: 32], exp[idx*32 +: 32]);
        end
    endtask

    // Reference block: queued words in order from slot 0, everything else zero.
    function automatic logic [BLK_W-1:0] model_block();
        logic [BLK_W-1:0] b;
        b = '0;
        foreach (mdl_q[i]) b[i*32 +: 32] = mdl_q[i];
        return b;
    endfunction

    // Offer one word (after `gap` idle cycles) and wait for the handshake; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input bit last, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            @(negedge aclk);
            s_valid = 1'b0;
        end
        @(negedge aclk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        waited  = 0;
        while (s_ready !== 1'b1 && waited < 200) begin
            @(negedge aclk);
            waited++;
        end
        if (s_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=s_ready_low required=s_ready_high");
            s_valid = 1'b0;
        end else begin
            @(posedge aclk);
            mdl_q.push_back(d);
        end
    endtask

    // Check a freshly closed block, hold it for `dly` cycles, then release it with core_done.
    task automatic check_block(input int expw, input int dly, input bit use_c,
                               input logic [63:0] lo, input logic [31:0] hi);
        logic [BLK_W-1:0] exp_b;
        bit stable;
        @(negedge aclk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        exp_b = model_block();
        chk("blk_valid_set", 64'(blk_valid), 64'd1);
        chk("s_ready_hold", 64'(s_ready), 64'd0);
        chk("blk_words", 64'(blk_words), 64'(expw));
        chk_blk("blk_data", blk_data, exp_b);
        if (use_c) begin
            chk("blk_lo64", blk_data[63:0], lo);
            chk("blk_hi32", 64'(blk_data[BLK_W-1 -: 32]), 64'(hi));
        end
        if (blk_valid === 1'b1) nblk++;
        stable = 1'b1;
        for (int c = 0; c < dly; c++) begin
            @(negedge aclk);
            if (blk_valid !== 1'b1 || s_ready !== 1'b0 || blk_data !== exp_b) stable = 1'b0;
        end
        chk("hold_stable", 64'(stable), 64'd1);
        core_done = 1'b1;
        @(negedge aclk);
        core_done = 1'b0;
        chk("blk_valid_clr", 64'(blk_valid), 64'd0);
        chk("s_ready_release", 64'(s_ready), 64'd1);
        chk_blk("blk_cleared", blk_data, '0);
        mdl_q.delete();
    endtask

    initial begin
        bit stable;
        logic [BLK_W-1:0] held;
        int len, nb0;
        bit lst;

        vecs[0] = '{64, 1'b1, 32'h1,         64, 64'h00000002_00000001, 32'd64};
        vecs[1] = '{ 3, 1'b1, 32'hA,          3, 64'h0000000B_0000000A, 32'd0};
        vecs[2] = '{ 1, 1'b1, 32'h55,         1, 64'h00000000_00000055, 32'd0};
        vecs[3] = '{64, 1'b0, 32'h100,       64, 64'h00000101_00000100, 32'h13F};
        vecs[4] = '{63, 1'b1, 32'h200,       63, 64'h00000201_00000200, 32'd0};
        vecs[5] = '{ 2, 1'b1, 32'hFFFF_FFF0,  2, 64'hFFFFFFF1_FFFFFFF0, 32'd0};

        aresetn   = 1'b0;
        s_data    = '0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        core_done = 1'b0;

        // Reset state
        repeat (3) @(negedge aclk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_blk_valid", 64'(blk_valid), 64'd0);
        chk("rst_blk_words", 64'(blk_words), 64'd0);
        chk("rst_err_done", 64'(err_done), 64'd0);
        chk_blk("rst_blk_data", blk_data, '0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("s_ready_after_rst", 64'(s_ready), 64'd1);

        // Table vectors: continuous streaming
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < vecs[i].nw; k++)
                send_word(vecs[i].base + 32'(k), vecs[i].last && (k == vecs[i].nw - 1), 0);
            check_block(vecs[i].exp_words, 2, 1'b1, vecs[i].exp_lo, vecs[i].exp_hi);
        end

        // Hold/backpressure: pending 0xDEAD across the hold and the done cycle
        for (int k = 0; k < 4; k++) send_word(32'h40 + 32'(k), k == 3, 0);
        @(negedge aclk);
        s_valid = 1'b1;
        s_data  = 32'hDEAD;
        s_last  = 1'b1;
        held = model_block();
        chk("bp_blk_valid", 64'(blk_valid), 64'd1);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge aclk);
            if (blk_data !== held || s_ready !== 1'b0 || blk_valid !== 1'b1) stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        core_done = 1'b1;
        @(negedge aclk);
        core_done = 1'b0;
        chk("bp_blk_valid_clr", 64'(blk_valid), 64'd0);
        chk("bp_s_ready", 64'(s_ready), 64'd1);
        chk_blk("bp_no_take_on_done", blk_data, '0);
        mdl_q.delete();
        @(posedge aclk);
        mdl_q.push_back(32'hDEAD);
        check_block(1, 1, 1'b1, 64'h00000000_0000DEAD, 32'd0);

        // Stray done in FILL after 5 words
        chk("err_before_stray", 64'(err_done), 64'd0);
        for (int k = 0; k < 5; k++) send_word(32'h500 + 32'(k), 1'b0, 0);
        @(negedge aclk);
        s_valid   = 1'b0;
        core_done = 1'b1;
        @(negedge aclk);
        core_done = 1'b0;
        chk("err_after_stray", 64'(err_done), 64'd1);
        chk("stray_no_block", 64'(blk_valid), 64'd0);
        for (int k = 5; k < 10; k++) send_word(32'h500 + 32'(k), k == 9, 0);
        check_block(10, 1, 1'b1, 64'h00000501_00000500, 32'd0);
        chk("err_sticky", 64'(err_done), 64'd1);

        // Reset mid-fill
        for (int k = 0; k < 10; k++) send_word(32'h900 + 32'(k), 1'b0, 0);
        #3;
        aresetn = 1'b0;
        #1;
        chk_blk("midrst_blk_data", blk_data, '0);
        chk("midrst_s_ready", 64'(s_ready), 64'd0);
        chk("midrst_blk_valid", 64'(blk_valid), 64'd0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        mdl_q.delete();
        @(negedge aclk);
        aresetn = 1'b1;
        chk("midrst_err_clr", 64'(err_done), 64'd0);
        for (int k = 0; k < 3; k++) send_word(32'hC0 + 32'(k), k == 2, 0);
        check_block(3, 0, 1'b1, 64'h000000C1_000000C0, 32'd0);

        // Randomized blocks with idle gaps and variable hold time
        for (int b = 0; b < 20; b++) begin
            len = $urandom_range(1, NW);
            lst = (len < NW) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++)
                send_word($urandom, lst && (k == len - 1), $urandom_range(0, 2));
            check_block(len, $urandom_range(0, 6), 1'b0, '0, '0);
        end

        // Back-to-back full blocks, done 5 cycles after each blk_valid
        nb0 = nblk;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < NW; k++) send_word(32'h1000 * 32'(b + 1) + 32'(k), k == NW - 1, 0);
            check_block(NW, 5, 1'b0, '0, '0);
        end
        chk("b2b_block_count", 64'(nblk - nb0), 64'd2);
        repeat (3) @(negedge aclk);
        chk("no_extra_block", 64'(blk_valid), 64'd0);
        chk("idle_s_ready", 64'(s_ready), 64'd1);
        chk("final_err_done", 64'(err_done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsa_word_packer.md
Name: rsa_word_packer

Overview:
- Upstream input stage for RSA_encryption / RSA_decryption.
- Accepts a narrow word stream (valid/ready) and packs it into one WIDTH*4-bit operand block.
- Presents the block as a level-held data/valid pair and holds it stable until the core pulses done, matching the core's In_Data_Ready / Decrypt_done contract.
- Short messages are terminated with s_last and zero-padded.

Parameters:
- WIDTH, 512, key-exponent width; block width BLK_W = WIDTH*4 (localparam).
- IN_W, 32, input stream word width; BLK_W % IN_W == 0 is required (elaboration assertion).
- NWORDS, localparam = BLK_W/IN_W (64 at defaults); counter width CW = $clog2(NWORDS+1).

Ports:
- aclk  in  1  clock, all state on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_data  in  IN_W  input stream word.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks final word of a message; qualified by s_valid.
- s_ready  out  1  packer accepts a word this cycle.
- blk_data  out  BLK_W  packed block; word k occupies bits [k*IN_W +: IN_W].
- blk_valid  out  1  block ready for core; level, held until core_done (drives In_Data_Ready).
- blk_words  out  CW  number of words loaded into current block (1..NWORDS), valid while blk_valid.
- core_done  in  1  single-cycle pulse from core (Decrypt_done / Encrypt_done).
- err_done  out  1  sticky: core_done seen while not holding a block.

Behaviour:
- Reset (async, aresetn=0):
  - state=FILL, cnt=0, blk_data=0, blk_valid=0, blk_words=0, err_done=0.
  - s_ready=0 while in reset; s_ready=1 from the first edge after release.
  - Reset mid-block discards partial data; no block is emitted.
- States: FILL, HOLD.
- FILL:
  - s_ready=1, blk_valid=0.
  - On a handshake (s_valid&&s_ready): blk_data[cnt*IN_W +: IN_W] <= s_data; cnt <= cnt+1.
  - If the handshake has s_last=1 or cnt==NWORDS-1: go to HOLD next edge, blk_words <= cnt+1, blk_valid=1 from that edge.
- HOLD:
  - s_ready=0; blk_data and blk_words are frozen.
  - s_valid is ignored, and the upstream word stays pending.
  - On core_done=1:
    - blk_valid drops at the next edge; state=FILL, cnt=0, blk_data cleared to 0 at the same edge.
    - s_ready=1 from that edge.
    - Minimum gap between blocks is 1 cycle.
- Zero-padding: slots at cnt..NWORDS-1 of a short block read 0, because the buffer is cleared on every entry to FILL.
- s_ready is registered/state-derived only; no combinational path from s_valid or core_done to s_ready.
- No word is ever lost or duplicated:
  - the word accepted on the edge that enters HOLD is stored;
  - no word is accepted in the cycle core_done is sampled.
- core_done in FILL: ignored for data/state; err_done <= 1, sticky until reset.
- core_done and s_valid in the same HOLD cycle: release the block only; the word is accepted in the following FILL cycle.
- s_last with cnt==NWORDS-1: a single full block; no extra empty block is produced.
- s_last on the first word: blk_words=1, remaining bits zero.
- Latency: last accepted word to blk_valid = 1 cycle; core_done to s_ready = 1 cycle.

Decomposition:
- Shared package rsa_pkg:
  - DEFAULT_WIDTH=512, DEFAULT_IN_W=32;
  - typedef enum logic {PK_FILL, PK_HOLD} pk_state_t.
- This block is reused by the RSA_decryption/RSA_encryption integration top.
- No sub-module: a single always_ff with a write-enable per slot is natural.
- The unpack direction (core output to stream) becomes a sibling block rsa_word_unpacker later, sharing rsa_pkg.

Test Plan:
- Full block: reset, stream 64 words s_data=k+1 (k=0..63) continuously with s_last on k=63.
  - blk_valid=1 one cycle after the last handshake; blk_words=64; blk_data[31:0]=1, blk_data[2047:2016]=64; s_ready=0.
- Short block: 3 words 0xA,0xB,0xC, s_last on 0xC.
  - blk_words=3, blk_data[95:0]=0x0000000C_0000000B_0000000A, bits [2047:96]=0.
- Hold/backpressure: in HOLD keep s_valid=1, s_data=0xDEAD for 10 cycles, then pulse core_done.
  - blk_data unchanged throughout; blk_valid=0 and s_ready=1 the next edge; 0xDEAD captured into slot 0 of the following block.
- Stray done: pulse core_done in FILL after 5 words loaded.
  - err_done=1 and stays 1; cnt and data are unaffected; the block completes normally.
- Reset mid-fill: load 10 words, assert aresetn=0 asynchronously mid-cycle.
  - blk_data=0 and cnt=0 immediately; the next block starts at slot 0.
- Back-to-back: two 64-word blocks, with core_done issued 5 cycles after each blk_valid.
  - Exactly 2 blocks with correct contents; no word lost or duplicated; 1-cycle gap between blocks.
